// File: rtl/instr_cache_responder.sv
// Direct-mapped I-cache: hit returns the word 1 cycle later, miss refills a line (4 handshakes + 2 cycles).
// Backpressure: stall holds the IF stage during miss/bypass; memory throttles through mem_ready.
module instr_cache_responder #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_enable,
    input  logic        invalidate,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);
    localparam int TAG_BITS = 32 - 2 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {IDLE, REFILL, BYPASS, RESPOND} state_t;

    state_t                 state;
    logic [OFFSET_BITS-1:0] cnt;
    logic [TAG_BITS-1:0]    l_tag;
    logic [INDEX_BITS-1:0]  l_idx;
    logic [OFFSET_BITS-1:0] l_off;
    logic                   inv_seen;
    logic [31:0]            resp_q;
    logic [LINES-1:0]       valid;

    logic [31:0]         data_mem [LINES][WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];

    logic [OFFSET_BITS-1:0] req_off;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]    req_tag;
    logic                   hit;
    logic [31:0]            rd_word;
    logic                   refill_accept;
    logic                   unused_addr_bits;

    assign req_off = fetch_addr[OFFSET_BITS+1:2];
    assign req_idx = fetch_addr[OFFSET_BITS+2 +: INDEX_BITS];
    assign req_tag = fetch_addr[31 -: TAG_BITS];
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_word = data_mem[req_idx][req_off];

    assign refill_accept = (state == REFILL) && mem_req && mem_ready;

    // Miss detection must stop the PC in the same cycle, so stall is not registered.
    assign stall = !reset &&
                   (((state == IDLE) && fetch_req && (!cache_enable || !hit)) ||
                    (state == REFILL) || (state == BYPASS));

    always_ff @(posedge clk) begin
        if (!reset && refill_accept) begin
            data_mem[l_idx][cnt] <= mem_data;
            if (cnt == LAST_WORD) begin
                tag_mem[l_idx] <= l_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            valid       <= '0;
            cnt         <= '0;
            l_tag       <= '0;
            l_idx       <= '0;
            l_off       <= '0;
            inv_seen    <= 1'b0;
            resp_q      <= '0;
        end else begin
            if (invalidate) begin
                valid <= '0;
            end
            case (state)
                IDLE: begin
                    fetch_valid <= 1'b0;
                    if (fetch_req) begin
                        if (!cache_enable) begin
                            state    <= BYPASS;
                            mem_req  <= 1'b1;
                            mem_addr <= {fetch_addr[31:2], 2'b00};
                        end else if (hit) begin
                            fetch_valid <= 1'b1;
                            fetch_instr <= rd_word;
                        end else begin
                            state    <= REFILL;
                            l_tag    <= req_tag;
                            l_idx    <= req_idx;
                            l_off    <= req_off;
                            cnt      <= '0;
                            inv_seen <= invalidate;
                            mem_req  <= 1'b1;
                            mem_addr <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
                        end
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        inv_seen <= 1'b1;
                    end
                    if (mem_req && mem_ready) begin
                        // One idle cycle on mem_req after every accepted word.
                        mem_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        if (cnt == l_off) begin
                            resp_q <= mem_data;
                        end
                        if (cnt == LAST_WORD) begin
                            state       <= RESPOND;
                            fetch_valid <= 1'b1;
                            fetch_instr <= (cnt == l_off) ? mem_data : resp_q;
                            if (!inv_seen && !invalidate) begin
                                valid[l_idx] <= 1'b1;
                            end
                        end
                    end else if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {l_tag, l_idx, cnt, 2'b00};
                    end
                end
                BYPASS: begin
                    if (mem_ready) begin
                        mem_req     <= 1'b0;
                        fetch_valid <= 1'b1;
                        fetch_instr <= mem_data;
                        state       <= RESPOND;
                    end
                end
                RESPOND: begin
                    fetch_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instr_cache_responder.md
Name: instr_cache_responder

Overview:
- Direct-mapped instruction cache that answers PC fetch requests from the IF stage. It returns the instruction word feeding the IF/ID buffer.
- On a miss it stalls the fetch side and refills a full line from main memory through a req/ready handshake.
- Sits between the instruction fetch logic and the instruction memory.
- With cache_enable low it acts as an uncached pass-through.

Parameters:
- INDEX_BITS, 4, log2 of number of lines (16 lines).
- OFFSET_BITS, 2, log2 of words per line (4 words, 16 bytes).
- Tag width is derived: 32-2-INDEX_BITS-OFFSET_BITS = 24 by default.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- cache_enable  in  1  1 = cached operation, 0 = uncached bypass.
- invalidate  in  1  one-cycle pulse; clears all valid bits.
- fetch_req  in  1  IF stage requests the word at fetch_addr.
- fetch_addr  in  32  byte PC; bits [1:0] ignored.
- fetch_valid  out  1  fetch_instr holds the requested word this cycle.
- fetch_instr  out  32  instruction word.
- stall  out  1  IF must hold PC and fetch_addr stable; drives pc_write/if_id_write gating.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned read address.
- mem_ready  in  1  memory has mem_data valid for current mem_addr this cycle.
- mem_data  in  32  read data.

Behaviour:
- Address split: offset = fetch_addr[OFFSET_BITS+1:2], index = next INDEX_BITS bits, tag = remaining upper bits.
- Reset values: fetch_valid=0, fetch_instr=0, stall=0, mem_req=0, mem_addr=0. All valid bits 0, FSM in IDLE. Data/tag arrays are not reset.
- FSM states: IDLE, REFILL, BYPASS, RESPOND.
- IDLE, fetch_req=1, cache_enable=1, hit (valid & tag match):
  - Next cycle fetch_valid=1 and fetch_instr=line word. Hit latency is 1 cycle (registered).
  - stall stays 0.
  - Back-to-back hits give one word per cycle.
- IDLE, fetch_req=1, cache_enable=1, miss:
  - Same cycle: stall=1 (combinational on miss detect).
  - Next cycle: enter REFILL. Latch tag/index/offset. Word counter = 0.
- REFILL:
  - mem_req=1, mem_addr = {tag, index, counter, 2'b00}.
  - mem_addr is held stable until mem_ready=1.
  - On mem_ready: write mem_data into data[index][counter] and increment counter.
  - On the last word: write tag, set valid unless an invalidate occurred during this refill, go to RESPOND.
  - mem_req is deasserted for one cycle after each accepted word, so there is at most one request per two cycles.
  - stall=1 throughout REFILL.
- RESPOND:
  - fetch_valid=1, fetch_instr = refilled word at the latched offset.
  - stall=0, go to IDLE.
  - Total miss penalty = 4 handshakes + 2 cycles.
- cache_enable=0 with fetch_req=1:
  - BYPASS: stall=1, mem_req=1, mem_addr = fetch_addr & ~3.
  - On mem_ready go to RESPOND with mem_data. The cache arrays are untouched.
  - Cached lines stay valid for later re-enable.
- cache_enable changing mid-REFILL or mid-BYPASS: the current transaction completes in its original mode. The new mode takes effect from IDLE.
- fetch_req=0 in IDLE: fetch_valid=0 next cycle; fetch_instr holds its last value.
- invalidate:
  - In IDLE: all valid bits clear at the next edge.
  - Invalidate and hit in the same cycle: the hit result is still returned.
  - During REFILL: the refill completes and the word is delivered, but valid is not set for that line.
- Wrap-around: the refill counter wraps 3->0 only at REFILL exit. Address 0xFFFF_FFF0 refill must not carry into the tag.
- reset mid-REFILL:
  - At the edge, FSM goes to IDLE and mem_req=0 next cycle.
  - Any partially written line stays invalid.
  - A late mem_ready is ignored.
- mem_ready while mem_req=0: ignored.

Test Plan:
- Reset, then fetch 0x00 -> stall=1; mem_addr sequence 0x00,0x04,0x08,0x0C (mem_ready after 1 cycle each); fetch_instr = word@0x00, fetch_valid=1; stall drops.
- Fetch 0x04, 0x08, 0x0C after that refill -> hits; fetch_valid=1 each cycle, no mem_req, instr = memory words.
- Fetch 0x100 (same index 0, tag 1) then 0x00 -> each misses and refills; evicts correctly; 0x00 word returned after second refill.
- invalidate pulse at the second handshake of a refill of 0x20 -> instr@0x20 delivered; refetch 0x20 misses again.
- cache_enable=0, fetch 0x04 (line valid) -> single mem_req with mem_addr=0x04; no array write; re-enable, fetch 0x04 hits.
- reset asserted during third refill word -> next cycle mem_req=0, stall=0, fetch_valid=0; refetch of that address misses.
